// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer behind EX: latches operands, drives the external
// multiplier and unsigned divider for a fixed latency, and owns HI/LO.
module muldiv_ctrl #(
    parameter int DIV_CYCLES = 33,
    parameter int MUL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_signed,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        div_en,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic [31:0] div_q,
    input  logic [31:0] div_r
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        mx_q, mx_d;
    logic [31:0]        my_q, my_d;
    logic [31:0]        dx_q, dx_d;
    logic [31:0]        dy_q, dy_d;
    logic               x_neg_q, x_neg_d;
    logic               y_neg_q, y_neg_d;
    logic               signed_q, signed_d;

    logic               req_signed_div;
    logic [31:0]        req_abs_x;
    logic [31:0]        req_abs_y;
    logic [31:0]        q_fix;
    logic [31:0]        r_fix;

    // The divider is unsigned: feed it magnitudes, then restore the signs of
    // quotient (sign of x xor y) and remainder (sign of the dividend).
    assign req_signed_div = (req_op == OP_DIV);
    assign req_abs_x      = (req_signed_div && req_x[31]) ? -req_x : req_x;
    assign req_abs_y      = (req_signed_div && req_y[31]) ? -req_y : req_y;
    assign q_fix          = (signed_q && (x_neg_q != y_neg_q)) ? -div_q : div_q;
    assign r_fix          = (signed_q && x_neg_q) ? -div_r : div_r;

    always_comb begin
        // NOTE: every next-state variable is defaulted to its current value
        // first, so no path through the case statement can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mx_d     = mx_q;
        my_d     = my_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        x_neg_d  = x_neg_q;
        y_neg_d  = y_neg_q;
        signed_d = signed_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    case (req_op)
                        OP_MULT, OP_MULTU: begin
                            mx_d     = req_x;
                            my_d     = req_y;
                            signed_d = (req_op == OP_MULT);
                            cnt_d    = CNT_W'(MUL_CYCLES - 1);
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (req_y != 32'd0) begin
                                dx_d     = req_abs_x;
                                dy_d     = req_abs_y;
                                x_neg_d  = req_x[31];
                                y_neg_d  = req_y[31];
                                signed_d = req_signed_div;
                                cnt_d    = CNT_W'(DIV_CYCLES - 1);
                                state_d  = S_DIV;
                            end else begin
                                state_d  = S_DONE;
                            end
                        end
                        OP_MTHI: hi_d = req_x;
                        OP_MTLO: lo_d = req_x;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = mul_hi;
                    lo_d    = mul_lo;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = r_fix;
                    lo_d    = q_fix;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            x_neg_q  <= 1'b0;
            y_neg_q  <= 1'b0;
            signed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            x_neg_q  <= x_neg_d;
            y_neg_q  <= y_neg_d;
            signed_q <= signed_d;
        end
    end

    // Stall is combinational so the requesting instruction freezes in cycle T.
    assign stall = !rst && !flush &&
                   ((state_q == S_MUL) || (state_q == S_DIV) ||
                    ((state_q == S_IDLE) && req_valid && !req_op[2]));

    assign div_en     = !rst && (state_q == S_DIV);
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign mul_signed = signed_q;
    assign mul_x      = mx_q;
    assign mul_y      = my_q;
    assign div_x      = dx_q;
    assign div_y      = dy_q;

endmodule
